// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end and the game-key decode.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes an asynchronous PS/2 clock line, debounces it with a stability
// filter and produces a one-cycle strobe on each accepted falling edge.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic fall
);

    localparam int unsigned CNT_W = 8;

    logic             meta;
    logic             sync;
    logic             filt;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer, idle-high like the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // A new level is accepted only after FILTER_LEN consecutive cycles of agreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b1;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                cnt  <= '0;
                filt <= sync;
                fall <= ~sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// Deserializes PS/2 keyboard frames and folds break/extended prefixes into a
// held makeBreak/outCode/extended result with code_valid and frame_err strobes.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       valid,
    output logic [7:0] outCode,
    output logic       makeBreak,
    output logic       extended,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             fall;
    logic             dat_meta;
    logic             dat_sync;

    ps2_state_t       state,      state_nx;
    logic [2:0]       bit_cnt,    bit_cnt_nx;
    logic [7:0]       shreg,      shreg_nx;
    logic             par_bit,    par_nx;
    logic             brk_pend,   brk_nx;
    logic             ext_pend,   ext_nx;
    logic [TMO_W-1:0] tmo_cnt,    tmo_nx;
    logic [7:0]       code_nx;
    logic             mb_nx;
    logic             ext_out_nx;
    logic             cv_nx;
    logic             fe_nx;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .raw   (PS2_CLK),
        .fall  (fall)
    );

    // Data needs no filtering: it is stable around the filtered clock edge.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
            tmo_cnt    <= '0;
            outCode    <= '0;
            makeBreak  <= 1'b0;
            extended   <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shreg      <= shreg_nx;
            par_bit    <= par_nx;
            brk_pend   <= brk_nx;
            ext_pend   <= ext_nx;
            tmo_cnt    <= tmo_nx;
            outCode    <= code_nx;
            makeBreak  <= mb_nx;
            extended   <= ext_out_nx;
            code_valid <= cv_nx;
            frame_err  <= fe_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        par_nx     = par_bit;
        brk_nx     = brk_pend;
        ext_nx     = ext_pend;
        tmo_nx     = tmo_cnt;
        code_nx    = outCode;
        mb_nx      = makeBreak;
        ext_out_nx = extended;
        cv_nx      = 1'b0;
        fe_nx      = 1'b0;

        if (fall) begin
            tmo_nx = '0;
            case (state)
                IDLE: begin
                    if (!dat_sync) begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end
                end
                DATA: begin
                    shreg_nx   = {dat_sync, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = PARITY;
                    end
                end
                PARITY: begin
                    par_nx   = dat_sync;
                    state_nx = STOP;
                end
                STOP: begin
                    state_nx = IDLE;
                    if (dat_sync && odd_parity_ok(shreg, par_bit)) begin
                        if (shreg == PS2_BREAK) begin
                            brk_nx = 1'b1;
                        end else if (shreg == PS2_EXT) begin
                            ext_nx = 1'b1;
                        end else begin
                            if (valid) begin
                                code_nx    = shreg;
                                mb_nx      = ~brk_pend;
                                ext_out_nx = ext_pend;
                                cv_nx      = 1'b1;
                            end
                            brk_nx = 1'b0;
                            ext_nx = 1'b0;
                        end
                    end else begin
                        // A corrupted byte must not leave a stale prefix behind.
                        fe_nx  = 1'b1;
                        brk_nx = 1'b0;
                        ext_nx = 1'b0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (state == IDLE) begin
            tmo_nx = '0;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_nx = IDLE;
            tmo_nx   = '0;
            fe_nx    = 1'b1;
            brk_nx   = 1'b0;
            ext_nx   = 1'b0;
        end else begin
            tmo_nx = tmo_cnt + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for the PS/2 scan-code receiver with a scaled-down bus clock
// and timeout so every scenario runs in a few thousand system cycles.
module tb_ps2_scancode_receiver;

    localparam int unsigned FILT    = 8;
    localparam int unsigned TMO     = 600;
    localparam int unsigned HALF    = 20;
    localparam int unsigned GAP     = 60;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic       valid    = 1'b1;
    logic [7:0] outCode;
    logic       makeBreak;
    logic       extended;
    logic       code_valid;
    logic       frame_err;

    int n_cmp  = 0;
    int n_err  = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int viol   = 0;
    logic cv_prev = 1'b0;
    logic fe_prev = 1'b0;
    int cv0;
    int fe0;

    ps2_scancode_receiver #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .valid      (valid),
        .outCode    (outCode),
        .makeBreak  (makeBreak),
        .extended   (extended),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Pulse counting and pulse-rule tracking, sampled away from the active edge.
    always @(negedge CLOCK_50) begin
        if (code_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
        if (code_valid && frame_err) viol++;
        if (code_valid && cv_prev) viol++;
        if (frame_err && fe_prev) viol++;
        cv_prev = code_valid;
        fe_prev = frame_err;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        PS2_DAT = b;
        wait_cycles(HALF);
        PS2_CLK = 1'b0;
        wait_cycles(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit((~^data) ^ par_flip);
        send_bit(stop);
        PS2_DAT = 1'b1;
        wait_cycles(GAP);
    endtask

    task automatic check_out(input string tag, input logic [7:0] code, input logic mb, input logic ext);
        check({tag, "_code"}, 32'(outCode), 32'(code));
        check({tag, "_mb"}, 32'(makeBreak), 32'(mb));
        check({tag, "_ext"}, 32'(extended), 32'(ext));
    endtask

    initial begin
        logic [7:0] partial;

        // Reset state
        wait_cycles(5);
        check_out("reset", 8'h00, 1'b0, 1'b0);
        check("reset_cv", 32'(code_valid), 32'd0);
        check("reset_fe", 32'(frame_err), 32'd0);
        reset = 1'b1;
        wait_cycles(20);

        // Plain make code
        cv0 = cv_cnt;
        send_frame(8'h6B, 1'b0, 1'b1);
        check("make_6b_pulses", 32'(cv_cnt - cv0), 32'd1);
        check_out("make_6b", 8'h6B, 1'b1, 1'b0);

        // Break sequence
        cv0 = cv_cnt;
        send_frame(8'hF0, 1'b0, 1'b1);
        check("f0_no_pulse", 32'(cv_cnt - cv0), 32'd0);
        check("f0_hold_mb", 32'(makeBreak), 32'd1);
        send_frame(8'h6B, 1'b0, 1'b1);
        check("brk_6b_pulses", 32'(cv_cnt - cv0), 32'd1);
        check_out("brk_6b", 8'h6B, 1'b0, 1'b0);

        // Extended break, then plain make clears both flags
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1);
        check_out("ext_brk_74", 8'h74, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        check_out("make_5a", 8'h5A, 1'b1, 1'b0);

        // Parity error
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h29, 1'b1, 1'b1);
        check("par_fe", 32'(fe_cnt - fe0), 32'd1);
        check("par_no_cv", 32'(cv_cnt - cv0), 32'd0);
        check_out("par_hold", 8'h5A, 1'b1, 1'b0);

        // Bad stop bit on a break prefix drops the prefix
        fe0 = fe_cnt;
        send_frame(8'hF0, 1'b0, 1'b0);
        check("stop_fe", 32'(fe_cnt - fe0), 32'd1);
        send_frame(8'h29, 1'b0, 1'b1);
        check_out("after_stop_29", 8'h29, 1'b1, 1'b0);

        // Timeout of a partial frame after a break prefix
        send_frame(8'hF0, 1'b0, 1'b1);
        fe0 = fe_cnt;
        cv0 = cv_cnt;
        partial = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        PS2_DAT = 1'b1;
        wait_cycles(TMO - 100);
        check("tmo_early", 32'(fe_cnt - fe0), 32'd0);
        wait_cycles(200);
        check("tmo_fe", 32'(fe_cnt - fe0), 32'd1);
        check("tmo_no_cv", 32'(cv_cnt - cv0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check_out("after_tmo_5a", 8'h5A, 1'b1, 1'b0);

        // Short clock glitches with data low must not start a frame
        fe0 = fe_cnt;
        cv0 = cv_cnt;
        PS2_DAT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            PS2_CLK = 1'b0;
            wait_cycles(3);
            PS2_CLK = 1'b1;
            wait_cycles(10);
        end
        PS2_DAT = 1'b1;
        wait_cycles(TMO + 100);
        check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
        check("glitch_no_cv", 32'(cv_cnt - cv0), 32'd0);
        send_frame(8'h74, 1'b0, 1'b1);
        check_out("after_glitch_74", 8'h74, 1'b1, 1'b0);

        // valid=0 discards the code but still consumes the prefix
        send_frame(8'hF0, 1'b0, 1'b1);
        cv0 = cv_cnt;
        valid = 1'b0;
        send_frame(8'h6B, 1'b0, 1'b1);
        valid = 1'b1;
        check("novalid_no_cv", 32'(cv_cnt - cv0), 32'd0);
        check_out("novalid_hold", 8'h74, 1'b1, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1);
        check_out("novalid_prefix_gone", 8'h29, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a frame
        send_frame(8'hE0, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        PS2_DAT = 1'b1;
        wait_cycles(3);
        #3;
        reset = 1'b0;
        #1;
        check_out("async_rst", 8'h00, 1'b0, 1'b0);
        wait_cycles(5);
        reset = 1'b1;
        wait_cycles(20);
        cv0 = cv_cnt;
        send_frame(8'h5A, 1'b0, 1'b1);
        check("post_rst_cv", 32'(cv_cnt - cv0), 32'd1);
        check_out("post_rst_5a", 8'h5A, 1'b1, 1'b0);

        check("pulse_rules", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
